// File: rtl/multi_bit_multiplexer_nway_arb_pkg.sv
// Shared constants and helpers for the N-way arbitrated multiplexer.
package multi_bit_multiplexer_nway_arb_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    // Ceiling log2, never less than 1 so select buses always have a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/multi_bit_multiplexer_nway_arb_rr_arbiter.sv
// Round-robin search: first requester after ptr, wrapping modulo CHANNELS.
module multi_bit_multiplexer_nway_arb_rr_arbiter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    index,
    output logic                found
);

    logic [SEL_W-1:0] cand;

    // Scan ptr+1 .. ptr+CHANNELS and keep the first requesting channel.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            cand = SEL_W'((32'(ptr) + k) % CHANNELS);
            if (!found && req[cand]) begin
                found       = 1'b1;
                index       = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_bit_multiplexer_nway_arb.sv
// N-way valid/ready multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output stage.
module multi_bit_multiplexer_nway_arb
    import multi_bit_multiplexer_nway_arb_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned MODE     = MODE_FIXED,
    localparam int unsigned SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          S,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic                load_en;
    logic [CHANNELS-1:0] raw_grant;
    logic [SEL_W-1:0]    raw_idx;
    logic                raw_found;
    logic                grant_any;
    logic [WIDTH-1:0]    sel_data;

    // Output register can take new data when empty or being drained.
    assign load_en = ~out_valid | out_ready;

    if (MODE != MODE_FIXED && MODE != MODE_RR) begin : g_bad_mode
        $error("multi_bit_multiplexer_nway_arb: unsupported MODE %0d", MODE);
    end

    if (MODE == MODE_RR) begin : g_rr
        logic [SEL_W-1:0] ptr;
        logic             unused_s;

        assign unused_s = ^S;

        multi_bit_multiplexer_nway_arb_rr_arbiter #(
            .CHANNELS (CHANNELS),
            .SEL_W    (SEL_W)
        ) u_rr_arbiter (
            .req   (in_valid),
            .ptr   (ptr),
            .grant (raw_grant),
            .index (raw_idx),
            .found (raw_found)
        );

        // Pointer moves to the winner only when its transfer is accepted.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ptr <= SEL_W'(CHANNELS - 1);
            end else if (load_en && raw_found) begin
                ptr <= raw_idx;
            end
        end
    end else begin : g_fixed
        // Grant channel S only if it exists and is requesting.
        always_comb begin
            raw_grant = '0;
            raw_idx   = S;
            raw_found = 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (S == SEL_W'(i) && in_valid[i]) begin
                    raw_grant[i] = 1'b1;
                    raw_found    = 1'b1;
                end
            end
        end
    end

    // Ready strobe only when the output stage can load and reset is released.
    always_comb begin
        in_ready  = '0;
        grant_any = 1'b0;
        if (reset_n && load_en && raw_found) begin
            in_ready  = raw_grant;
            grant_any = 1'b1;
        end
    end

    // One-hot AND-OR data select; no path from data to control.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (raw_grant[i]) begin
                sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Single output register stage; holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load_en) begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_data <= sel_data;
                out_chan <= raw_idx;
            end
        end
    end

endmodule
